// File: rtl/clk_en_sched.sv
// Purpose: multi-channel clock-enable scheduler. Each channel emits a one-cycle
//   tick strobe every D system clocks plus a 50%-duty square wave (period 2*D).
// Latency: tick/sq are registered; a tick is high in the cycle after the
//   channel counter reaches D-1.
// Backpressure: cfg_ready drops while a divisor change waits for the target
//   channel's period boundary; only one config request is in flight.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   cfg_valid/ready  config handshake (accept when both high)
//   cfg_ch           target channel (indices >= NUM_CH are accepted and dropped)
//   cfg_div          new divisor (0 is stored as 1)
//   cfg_en           channel enable applied together with the divisor
//   sync             realign every channel phase to counter 0, sq 0
//   tick             per-channel single-cycle strobe
//   sq               per-channel square wave, toggles with each tick
module clk_en_sched #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  typedef enum logic {
    IDLE,
    WAIT_WRAP
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] sq_q;

  logic [CH_W-1:0]   pend_ch_q;
  logic [DIV_W-1:0]  pend_div_q;
  logic              pend_en_q;

  logic              accept;
  logic              ch_ok;
  logic [DIV_W-1:0]  cfg_div_c;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] ld;      // channel loads div/en at this edge
  logic [DIV_W-1:0]  ld_div;
  logic              ld_en;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign cfg_ready = (state_q == IDLE) && !reset;
  assign accept    = cfg_valid && cfg_ready;
  assign ch_ok     = int'(cfg_ch) < NUM_CH;
  // Coercing 0 to 1 here keeps div-1 from underflowing in the wrap compare.
  assign cfg_div_c = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  // A channel is at its period boundary when enabled and at D-1.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = en_q[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
    end
  end

  // Next-state and load selection.
  always_comb begin
    state_d = state_q;
    ld      = '0;
    ld_div  = pend_div_q;
    ld_en   = pend_en_q;
    case (state_q)
      IDLE: begin
        if (accept && ch_ok) begin
          ld_div = cfg_div_c;
          ld_en  = cfg_en;
          // A disabled channel has no phase to protect, and sync discards
          // the phase anyway, so the change lands immediately.
          if (sync || !en_q[cfg_ch]) begin
            ld[cfg_ch] = 1'b1;
          end else begin
            state_d = WAIT_WRAP;
          end
        end
      end
      WAIT_WRAP: begin
        if (sync || wrap[pend_ch_q]) begin
          ld[pend_ch_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config FSM and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      pend_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_ch_q  <= cfg_ch;
        pend_div_q <= cfg_div_c;
        pend_en_q  <= cfg_en;
      end
    end
  end

  // Per-channel counters, strobes and square waves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_W'(DEFAULT_DIV);
      end
      en_q   <= '1;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync || !en_q[i]) begin
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
          sq_q[i]   <= 1'b0;
        end else if (wrap[i]) begin
          // The last tick of the old period is always issued; a disable
          // landing here clears the square wave on the same edge.
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b1;
          sq_q[i]   <= (ld[i] && !ld_en) ? 1'b0 : ~sq_q[i];
        end else begin
          cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
          tick_q[i] <= 1'b0;
        end
        if (ld[i]) begin
          div_q[i] <= ld_div;
          en_q[i]  <= ld_en;
        end
      end
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: tb/tb_clk_en_sched.sv
module tb_clk_en_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_en;
  logic        sync;
  logic [3:0]  tick;
  logic [3:0]  sq;

  int checks = 0;
  int errors = 0;

  clk_en_sched #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .sync      (sync),
    .tick      (tick),
    .sq        (sq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] d, input logic e);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_en    = e;
  endtask

  task automatic idle_in();
    cfg_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    step();
    step();
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq, 0);
    chk("rst_rdy", cfg_ready, 0);
    reset = 1'b0;
  endtask

  // Default D=2 on every channel: ticks on even cycles, sq period 4.
  function automatic logic [3:0] dflt_tick(input int c);
    return (c % 2 == 0) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] dflt_sq(input int c);
    return ((c / 2) % 2 == 1) ? 4'hF : 4'h0;
  endfunction

  initial begin
    logic [3:0] et;
    logic [3:0] es;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_en  = 1'b0;

    // Defaults for 20 cycles.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) chk("t1_rdy", cfg_ready, 1);
      chk($sformatf("t1_tick_c%0d", c), tick, dflt_tick(c));
      chk($sformatf("t1_sq_c%0d", c), sq, dflt_sq(c));
    end

    // ch1 D=2 -> 5; accepted at the start of cycle 5, boundary at edge 6.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("t2_tick_c%0d", c), tick, dflt_tick(c));
    end
    chk("t2_rdy_c4", cfg_ready, 1);
    cfg(2'd1, 16'd5, 1'b1);
    step();
    idle_in();
    chk("t2_rdy_c5", cfg_ready, 0);
    chk("t2_tick_c5", tick, 4'h0);
    chk("t2_sq_c5", sq, 4'h0);
    for (int c = 6; c <= 16; c++) begin
      step();
      et = ((c % 2 == 0) ? 4'b1101 : 4'b0000) | ((c == 6 || c == 11 || c == 16) ? 4'b0010 : 4'b0000);
      es = (((c / 2) % 2 == 1) ? 4'b1101 : 4'b0000) | ((c < 11 || c == 16) ? 4'b0010 : 4'b0000);
      chk($sformatf("t2_rdy_c%0d", c), cfg_ready, 1);
      chk($sformatf("t2_tick_c%0d", c), tick, et);
      chk($sformatf("t2_sq_c%0d", c), sq, es);
    end

    // ch2 div=0 -> stored as 1; applied at the edge-4 boundary.
    do_reset();
    step();
    chk("t3_tick_c1", tick, 4'h0);
    cfg(2'd2, 16'd0, 1'b1);
    step();
    idle_in();
    chk("t3_rdy_c2", cfg_ready, 0);
    chk("t3_tick_c2", tick, 4'hF);
    chk("t3_sq_c2", sq, 4'hF);
    step();
    chk("t3_rdy_c3", cfg_ready, 0);
    chk("t3_tick_c3", tick, 4'h0);
    chk("t3_sq_c3", sq, 4'hF);
    for (int c = 4; c <= 10; c++) begin
      step();
      et = ((c % 2 == 0) ? 4'hF : 4'h0) | 4'b0100;
      es = (((c / 2) % 2 == 1) ? 4'b1011 : 4'b0000) | ((c % 2 == 1) ? 4'b0100 : 4'b0000);
      chk($sformatf("t3_rdy_c%0d", c), cfg_ready, 1);
      chk($sformatf("t3_tick_c%0d", c), tick, et);
      chk($sformatf("t3_sq_c%0d", c), sq, es);
    end

    // ch3 disable at its boundary, then re-enable with D=3.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      step();
      et = (dflt_tick(c) & 4'b0111) | ((c == 2 || c == 4 || c == 13 || c == 16) ? 4'b1000 : 4'b0000);
      es = (dflt_sq(c) & 4'b0111) | ((c == 2 || c == 3 || (c >= 13 && c < 16)) ? 4'b1000 : 4'b0000);
      chk($sformatf("t4_rdy_c%0d", c), cfg_ready, (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("t4_tick_c%0d", c), tick, et);
      chk($sformatf("t4_sq_c%0d", c), sq, es);
      if (c == 1) cfg(2'd3, 16'd2, 1'b0);
      else if (c == 9) cfg(2'd3, 16'd3, 1'b1);
      else idle_in();
    end

    // ch0 D=4, ch1 D=6, then sync while ch1 waits with pending D=3.
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 2 || c == 3 || c == 5 || c == 7)
        chk($sformatf("t5_rdy_c%0d", c), cfg_ready, 0);
      else if (c >= 4)
        chk($sformatf("t5_rdy_c%0d", c), cfg_ready, 1);
      if (c >= 8) begin
        et[0] = (c == 12 || c == 16);
        et[1] = (c == 11 || c == 14 || c == 17);
        et[2] = (c == 10 || c == 12 || c == 14 || c == 16);
        et[3] = et[2];
        es[0] = (c >= 12 && c < 16);
        es[1] = (c >= 11 && c < 14) || (c >= 17);
        es[2] = (c >= 10 && c < 12) || (c >= 14 && c < 16);
        es[3] = es[2];
        chk($sformatf("t5_tick_c%0d", c), tick, et);
        chk($sformatf("t5_sq_c%0d", c), sq, es);
      end
      if (c == 7) begin
        cfg_valid = 1'b0;
        sync      = 1'b1;
      end else if (c == 1) cfg(2'd0, 16'd4, 1'b1);
      else if (c == 4) cfg(2'd1, 16'd6, 1'b1);
      else if (c == 6) cfg(2'd1, 16'd3, 1'b1);
      else idle_in();
    end

    // Reset while ch0 waits for its boundary with pending D=7.
    do_reset();
    step();
    cfg(2'd0, 16'd7, 1'b1);
    step();
    idle_in();
    chk("t6_rdy_wait", cfg_ready, 0);
    reset = 1'b1;
    step();
    chk("t6_rst_tick", tick, 4'h0);
    chk("t6_rst_sq", sq, 4'h0);
    chk("t6_rst_rdy", cfg_ready, 0);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("t6_rdy_c%0d", c), cfg_ready, 1);
      chk($sformatf("t6_tick_c%0d", c), tick, dflt_tick(c));
      chk($sformatf("t6_sq_c%0d", c), sq, dflt_sq(c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
